mult_div_unit: RTL

//  Execute-stage HI/LO multiply/divide unit; consumes the 4-bit mult_div_sel_E start code

---
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Execute-stage HI/LO multiply/divide unit.
//   - mult/multu/div/divu are multi-cycle. They latch A, B and the op, run for
//     MULT_CYCLES or DIV_CYCLES cycles, and write HI/LO on the final cycle.
//   - mthi/mtlo write HI or LO directly at the next edge.
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous, active-high reset
//   md_sel  in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                    7-15 none
//   A       in  32   rs operand (forwarded)
//   B       in  32   rt operand (forwarded)
//   start   out  1   combinational: md_sel is 1..4 this cycle
//   busy    out  1   registered: multi-cycle op in flight (state == RUN)
//   hi      out 32   HI register
//   lo      out 32   LO register
//
// Handshake: there is no ready. The unit accepts md_sel only in IDLE. While
// busy=1, md_sel/A/B are ignored, so the hazard unit must hold dependent
// instructions in D while (start | busy).
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_sel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic [3:0]      op_q, op_d;
   logic [31:0]     hi_q, hi_d, lo_q, lo_d;

   // Arithmetic on the latched operands; only sampled on the final RUN edge.
   logic [63:0]     prod_s, prod_u;
   logic [31:0]     mag_a, mag_b, den_s, den_u;
   logic [31:0]     uq_s, ur_s, q_s, r_s, q_u, r_u;

   always_comb begin
      prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u = {32'b0, a_q} * {32'b0, b_q};

      // Signed divide through magnitudes. This handles 0x80000000 / -1
      // without overflow: the quotient magnitude 0x80000000 negates to itself.
      mag_a  = a_q[31] ? (32'd0 - a_q) : a_q;
      mag_b  = b_q[31] ? (32'd0 - b_q) : b_q;
      // A zero divisor never writes HI/LO. Using 1 instead keeps the
      // divider free of divide-by-zero.
      den_s  = (b_q == 32'd0) ? 32'd1 : mag_b;
      den_u  = (b_q == 32'd0) ? 32'd1 : b_q;
      uq_s   = mag_a / den_s;
      ur_s   = mag_a % den_s;
      q_s    = (a_q[31] ^ b_q[31]) ? (32'd0 - uq_s) : uq_s;
      r_s    = a_q[31] ? (32'd0 - ur_s) : ur_s;
      q_u    = a_q / den_u;
      r_u    = a_q % den_u;
   end

   // Next-state / datapath process.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            case (md_sel)
               OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  a_d     = A;
                  b_d     = B;
                  op_d    = md_sel;
                  cnt_d   = (md_sel == OP_MULT || md_sel == OP_MULTU) ?
                            CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  state_d = S_RUN;
               end
               OP_MTHI: hi_d = A;
               OP_MTLO: lo_d = A;
               default: ;
            endcase
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_DIV: begin
                     if (b_q != 32'd0) begin
                        lo_d = q_s;
                        hi_d = r_s;
                     end
                  end
                  OP_DIVU: begin
                     if (b_q != 32'd0) begin
                        lo_d = q_u;
                        hi_d = r_u;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign start = (md_sel >= OP_MULT) && (md_sel <= OP_DIVU);
   assign busy  = (state_q == S_RUN);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
